// File: rtl/bus_model_pkg.sv
// Shared types and helpers for the bus memory model: FSM state, address join and
// saturating counter increment.
package bus_model_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, SERVE} bus_state_t;

   localparam logic [15:0] DEFAULT_SLOW_BASE = 16'h8000;
   localparam logic [15:0] DEFAULT_ROM_BASE  = 16'hF000;

   // Joins the CPU's split address bus; callers cast down to their own width.
   function automatic logic [31:0] joinAddress(input logic [23:0] high, input logic [7:0] low);
      return {high, low};
   endfunction

   function automatic logic [31:0] satIncrement(input logic [31:0] value, input logic [31:0] maxValue);
      return (value >= maxValue) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/wait_state_counter.sv
// Loadable down-counter for wait-state timing; restart reloads, zero flag ends the wait.
module wait_state_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             restart,
   input  logic             decrement,
   input  logic [WIDTH-1:0] loadValue,
   output logic             isZero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= '0;
      end else if (restart) begin
         count <= loadValue;
      end else if (decrement && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign isZero = (count == '0);

endmodule

// File: rtl/bus_memory_model.sv
// Memory responder for the top8227 CPU bus with slow-region wait states, preload port
// and saturating access counters. Define ROM_PROTECT_EN to write-protect ROM_BASE..top.
//
// state | meaning
// IDLE  | fast or repeated accesses complete every cycle; a new slow access stalls here
// WAIT  | ready low while the remaining wait states count down
// SERVE | ready high for the completing cycle of a slow access
module bus_memory_model
   import bus_model_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                DEPTH       = 65536,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] SLOW_BASE   = ADDR_W'(DEFAULT_SLOW_BASE),
   parameter logic [ADDR_W-1:0] ROM_BASE    = ADDR_W'(DEFAULT_ROM_BASE),
   parameter int                COUNT_W     = 16
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [ADDR_W-9:0]   AddressBusHigh,
   input  logic [7:0]          AddressBusLow,
   input  logic                readNotWrite,
   input  logic [7:0]          dataBusOutput,
   output logic [7:0]          dataBusInput,
   output logic                ready,
   input  logic                loadEnable,
   input  logic [ADDR_W-1:0]   loadAddress,
   input  logic [7:0]          loadData,
   output logic [COUNT_W-1:0]  readCount,
   output logic [COUNT_W-1:0]  writeCount,
   output logic                romWriteError
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   // The IDLE cycle that detects the access is itself the first ready-low cycle.
   localparam logic [3:0]        WS_LOAD   = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;
`ifdef ROM_PROTECT_EN
   localparam bit                ROM_PROTECT = 1'b1;
`else
   localparam bit                ROM_PROTECT = 1'b0;
`endif

   bus_state_t        state, nextState;
   logic [ADDR_W-1:0] addr, prevAddr, lastAddr;
   logic [IDX_W-1:0]  addrIdx, loadIdx;
   logic              prevRnW, lastRnW, primed;
   logic              newAccess, slow, addrChanged, romHit;
   logic              fsmReady, complete, cpuWrite;
   logic              cntLoad, cntDec, cntZero;
   logic [7:0]        mem [DEPTH];

   assign addr        = ADDR_W'(joinAddress(24'(AddressBusHigh), AddressBusLow)) & ADDR_MASK;
   assign addrIdx     = addr[IDX_W-1:0];
   assign loadIdx     = loadAddress[IDX_W-1:0];
   assign newAccess   = !primed || (addr != prevAddr) || (readNotWrite != prevRnW);
   assign slow        = (WAIT_STATES > 0) && (addr >= SLOW_BASE);
   assign addrChanged = (addr != lastAddr) || (readNotWrite != lastRnW);
   assign romHit      = ROM_PROTECT && (addr >= ROM_BASE);

   assign ready    = fsmReady | ~nrst;
   assign complete = fsmReady & nrst;
   assign cpuWrite = complete & ~readNotWrite & ~romHit;

   wait_state_counter #(.WIDTH(4)) u_waitCounter (
      .clk       (clk),
      .nrst      (nrst),
      .restart   (cntLoad),
      .decrement (cntDec),
      .loadValue (WS_LOAD),
      .isZero    (cntZero)
   );

   always_comb begin
      nextState = state;
      fsmReady  = 1'b1;
      cntLoad   = 1'b0;
      cntDec    = 1'b0;
      case (state)
         IDLE: begin
            if (newAccess && slow) begin
               fsmReady  = 1'b0;
               cntLoad   = 1'b1;
               nextState = (WAIT_STATES == 1) ? SERVE : WAIT;
            end
         end
         WAIT: begin
            fsmReady = 1'b0;
            if (addrChanged) begin
               cntLoad = 1'b1;
            end else if (cntZero) begin
               nextState = SERVE;
            end else begin
               cntDec = 1'b1;
            end
         end
         SERVE:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= IDLE;
         primed        <= 1'b0;
         prevAddr      <= '0;
         prevRnW       <= 1'b1;
         lastAddr      <= '0;
         lastRnW       <= 1'b1;
         dataBusInput  <= 8'h00;
         readCount     <= '0;
         writeCount    <= '0;
         romWriteError <= 1'b0;
      end else begin
         state         <= nextState;
         lastAddr      <= addr;
         lastRnW       <= readNotWrite;
         romWriteError <= complete & ~readNotWrite & romHit;
         if (complete) begin
            prevAddr <= addr;
            prevRnW  <= readNotWrite;
            primed   <= 1'b1;
            if (readNotWrite) begin
               dataBusInput <= mem[addrIdx];
               readCount    <= COUNT_W'(satIncrement(32'(readCount), 32'(COUNT_MAX)));
            end else begin
               writeCount   <= COUNT_W'(satIncrement(32'(writeCount), 32'(COUNT_MAX)));
            end
         end
      end
   end

   // Preload is applied last so it overrides a CPU write to the same location.
   always_ff @(posedge clk) begin
      if (cpuWrite) begin
         mem[addrIdx] <= dataBusOutput;
      end
      if (loadEnable) begin
         mem[loadIdx] <= loadData;
      end
   end

endmodule
